// File: rtl/seq_math_pkg.sv
// Shared types and sizing helpers for the sequential math coprocessor.
package seq_math_pkg;

    typedef enum logic [1:0] {
        M_DIV   = 2'd0,
        M_RECIP = 2'd1,
        M_SQRT  = 2'd2,
        M_BAD   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_ROUND,
        S_DONE
    } state_t;

    // Result width: integer part plus fraction bits.
    function automatic int unsigned calc_rw(input int unsigned w, input int unsigned fw);
        return w + fw;
    endfunction

    // Quotient bits produced by DIV/RECIP; one extra bit feeds the half-LSB rounding.
    function automatic int unsigned div_iters(input int unsigned w, input int unsigned fw);
        return w + fw + 1;
    endfunction

    // Square root consumes two radicand bits per iteration.
    function automatic int unsigned sqrt_iters(input int unsigned w);
        return w / 2;
    endfunction

    // Partial remainder width, one bit above the quotient width for the trial carry.
    function automatic int unsigned calc_pw(input int unsigned w, input int unsigned fw);
        return w + fw + 2;
    endfunction

endpackage

// File: rtl/seq_math_unit_cond_sub_step.sv
// Combinational trial subtract: keeps the minuend when the subtract would borrow.
module cond_sub_step #(
    parameter int unsigned Width = 26
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic             borrow_o,
    output logic [Width-1:0] res_o
);

    logic [Width:0] diff;

    // Extended subtract; the top bit is the borrow.
    always_comb begin
        diff     = {1'b0, a_i} - {1'b0, b_i};
        borrow_o = diff[Width];
        res_o    = diff[Width] ? a_i : diff[Width-1:0];
    end

endmodule

// File: rtl/seq_math_unit.sv
// Sequential divide / reciprocal / integer square root with half-LSB upward rounding.
module seq_math_unit
    import seq_math_pkg::*;
#(
    parameter int unsigned W  = 16,
    parameter int unsigned FW = 8
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            start,
    input  logic [1:0]      mode,
    input  logic [W-1:0]    opA,
    input  logic [W-1:0]    opB,
    output logic            busy,
    output logic            done,
    output logic [W+FW-1:0] result,
    output logic            err
);

    localparam int unsigned RW = calc_rw(W, FW);
    localparam int unsigned NW = div_iters(W, FW);
    localparam int unsigned PW = calc_pw(W, FW);
    localparam int unsigned H  = sqrt_iters(W);
    localparam int unsigned CW = $clog2(NW + 1);

    state_t          state_q;
    mode_t           op_q;
    logic [CW-1:0]   cnt_q;
    logic [NW-1:0]   num_q;   // dividend bits shift out, quotient bits shift in
    logic [W-1:0]    div_q;
    logic [W-1:0]    rad_q;
    logic [H-1:0]    root_q;
    logic [PW-1:0]   rem_q;

    logic [PW-1:0]   step_a;
    logic [PW-1:0]   step_b;
    logic [PW-1:0]   step_res;
    logic            step_borrow;
    logic [CW-1:0]   last_cnt;
    logic [NW-1:0]   q_inc;
    logic [RW-1:0]   div_res;
    logic            sq_up;
    logic [H:0]      sq_r;
    logic [H-1:0]    sq_sat;
    logic [RW-1:0]   sqrt_res;
    logic            bad_req;
    mode_t           req_mode;

    // Route the shared trial subtractor to the divide or square-root partials.
    always_comb begin
        step_a = {rem_q[PW-2:0], num_q[NW-1]};
        step_b = {{(PW-W){1'b0}}, div_q};
        if (op_q == M_SQRT) begin
            step_a = {rem_q[PW-3:0], rad_q[W-1 -: 2]};
            step_b = {{(PW-H-2){1'b0}}, root_q, 2'b01};
        end
    end

    cond_sub_step #(
        .Width (PW)
    ) u_step (
        .a_i      (step_a),
        .b_i      (step_b),
        .borrow_o (step_borrow),
        .res_o    (step_res)
    );

    // Request decode, iteration bound and final rounding of both datapaths.
    always_comb begin
        req_mode = mode_t'(mode);
        bad_req  = (req_mode == M_BAD) ||
                   ((req_mode == M_DIV) && (opB == '0)) ||
                   ((req_mode == M_RECIP) && (opA == '0));
        last_cnt = (op_q == M_SQRT) ? CW'(H - 1) : CW'(NW - 1);
        // Q never reaches all ones, so the increment cannot wrap.
        q_inc    = num_q + NW'(1);
        div_res  = RW'(q_inc >> 1);
        sq_up    = rem_q > {{(PW-H){1'b0}}, root_q};
        sq_r     = {1'b0, root_q} + {{H{1'b0}}, sq_up};
        sq_sat   = sq_r[H] ? {H{1'b1}} : sq_r[H-1:0];
        sqrt_res = {{(RW-H){1'b0}}, sq_sat};
    end

    // Control FSM with registered outputs and operand/partial registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IDLE;
            op_q    <= M_DIV;
            cnt_q   <= '0;
            num_q   <= '0;
            div_q   <= '0;
            rad_q   <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    if (start) begin
                        op_q   <= req_mode;
                        cnt_q  <= '0;
                        rem_q  <= '0;
                        root_q <= '0;
                        rad_q  <= opA;
                        div_q  <= (req_mode == M_RECIP) ? opA : opB;
                        num_q  <= (req_mode == M_RECIP) ? {1'b1, {(NW-1){1'b0}}}
                                                        : {opA, {(FW+1){1'b0}}};
                        if (bad_req) begin
                            state_q <= S_DONE;
                            done    <= 1'b1;
                            err     <= 1'b1;
                            result  <= '1;
                        end else begin
                            state_q <= S_ITER;
                            busy    <= 1'b1;
                        end
                    end
                end
                S_ITER: begin
                    rem_q <= step_res;
                    if (op_q == M_SQRT) begin
                        root_q <= {root_q[H-2:0], ~step_borrow};
                        rad_q  <= {rad_q[W-3:0], 2'b00};
                    end else begin
                        num_q <= {num_q[NW-2:0], ~step_borrow};
                    end
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == last_cnt) begin
                        state_q <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    result  <= (op_q == M_SQRT) ? sqrt_res : div_res;
                    err     <= 1'b0;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_math_unit.sv
// Directed bench for seq_math_unit with a queue scoreboard and golden models.
module tb_seq_math_unit;

    localparam int unsigned W  = 16;
    localparam int unsigned FW = 8;
    localparam int unsigned RW = W + FW;
    // done is seen after the (N+2)th edge, counting the accepting edge as the first.
    localparam int LAT_DIV  = W + FW + 1 + 2;
    localparam int LAT_SQRT = W / 2 + 2;
    localparam int LAT_ERR  = 1;

    logic          CLK = 1'b0;
    logic          Reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [W-1:0]  opA = '0;
    logic [W-1:0]  opB = '0;
    logic          busy;
    logic          done;
    logic [RW-1:0] result;
    logic          err;

    typedef struct {
        logic [RW-1:0] res;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    seq_math_unit #(
        .W  (W),
        .FW (FW)
    ) dut (
        .CLK    (CLK),
        .Reset  (Reset),
        .start  (start),
        .mode   (mode),
        .opA    (opA),
        .opB    (opB),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    // Arithmetic golden model, written from the mathematical definitions.
    function automatic exp_t model(input logic [1:0] m, input longint unsigned a,
                                   input longint unsigned b);
        exp_t             x;
        longint unsigned  q;
        longint unsigned  f;
        longint unsigned  rem;
        x.err = 1'b0;
        x.res = '0;
        if (m == 2'd3 || (m == 2'd0 && b == 0) || (m == 2'd1 && a == 0)) begin
            x.err = 1'b1;
            x.res = '1;
        end else if (m == 2'd0) begin
            q     = (a << (FW + 1)) / b;
            x.res = RW'((q + 1) >> 1);
        end else if (m == 2'd1) begin
            q     = (64'd1 << (W + FW)) / a;
            x.res = RW'((q + 1) >> 1);
        end else begin
            f = 0;
            while ((f + 1) * (f + 1) <= a) f++;
            rem = a - f * f;
            if (rem > f) f++;
            if (f == (64'd1 << (W / 2))) f--;
            x.res = RW'(f);
        end
        return x;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a request for one cycle and record its expected outcome.
    task automatic launch(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_q.push_back(model(m, a, b));
        start = 1'b1;
        mode  = m;
        opA   = a;
        opB   = b;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done, then pop the scoreboard and compare.
    task automatic wait_done(input string tag, input int n0, input int lat);
        int   n;
        exp_t x;
        n = n0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(lat));
        if (exp_q.size() == 0) begin
            chk({tag, " scoreboard empty"}, 64'(1), 64'(0));
        end else begin
            x = exp_q.pop_front();
            if (done === 1'b1) begin
                chk({tag, " result"}, 64'(result), 64'(x.res));
                chk({tag, " err"}, 64'(err), 64'(x.err));
                chk({tag, " busy at done"}, 64'(busy), 64'(0));
                last_exp = x;
            end
        end
    endtask

    task automatic run(input string tag, input logic [1:0] m, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int lat);
        @(negedge CLK);
        launch(m, a, b);
        if (lat > 1) chk({tag, " busy"}, 64'(busy), 64'(1));
        wait_done(tag, 1, lat);
        @(posedge CLK);
        #1;
        chk({tag, " done pulse"}, 64'(done), 64'(0));
    endtask

    task automatic idle_check(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(posedge CLK);
            #1;
            if (done === 1'b1) seen++;
        end
        chk(tag, 64'(seen), 64'(0));
    endtask

    initial begin
        int n;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (3) @(posedge CLK);
        #1;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset result", 64'(result), 64'(0));
        chk("reset err", 64'(err), 64'(0));
        Reset = 1'b0;

        run("sqrt 16", 2'd2, 16'd16, 16'd0, LAT_SQRT);
        chk("sqrt 16 literal", 64'(last_exp.res), 64'h000004);
        run("sqrt 12", 2'd2, 16'd12, 16'd0, LAT_SQRT);
        run("sqrt 13", 2'd2, 16'd13, 16'd0, LAT_SQRT);
        run("sqrt ffff", 2'd2, 16'hFFFF, 16'd0, LAT_SQRT);
        chk("sqrt ffff literal", 64'(last_exp.res), 64'h0000FF);
        run("sqrt 0", 2'd2, 16'd0, 16'd0, LAT_SQRT);
        run("sqrt 2", 2'd2, 16'd2, 16'd0, LAT_SQRT);

        run("div 1/3", 2'd0, 16'd1, 16'd3, LAT_DIV);
        chk("div 1/3 literal", 64'(last_exp.res), 64'h000055);
        run("div 2/3", 2'd0, 16'd2, 16'd3, LAT_DIV);
        run("div ffff/1", 2'd0, 16'hFFFF, 16'd1, LAT_DIV);
        chk("div ffff/1 literal", 64'(last_exp.res), 64'hFFFF00);

        run("recip 1", 2'd1, 16'd1, 16'd0, LAT_DIV);
        chk("recip 1 literal", 64'(last_exp.res), 64'h800000);
        run("recip 3", 2'd1, 16'd3, 16'd0, LAT_DIV);
        run("recip ffff", 2'd1, 16'hFFFF, 16'd0, LAT_DIV);

        run("div by 0", 2'd0, 16'd5, 16'd0, LAT_ERR);
        run("recip 0", 2'd1, 16'd0, 16'd9, LAT_ERR);
        run("mode 3", 2'd3, 16'd7, 16'd7, LAT_ERR);
        run("div after err", 2'd0, 16'd100, 16'd7, LAT_DIV);

        for (int i = 0; i < 4; i++) begin
            ra = W'($urandom);
            rb = W'($urandom_range(1, 16'hFFFF));
            run("div rand", 2'd0, ra, rb, LAT_DIV);
            run("sqrt rand", 2'd2, ra, 16'd0, LAT_SQRT);
        end

        // start while busy must be ignored and result held meanwhile.
        @(negedge CLK);
        launch(2'd0, 16'd7, 16'd2);
        n = 1;
        repeat (3) begin
            @(posedge CLK);
            #1;
            n++;
        end
        start = 1'b1;
        mode  = 2'd2;
        opA   = 16'd9;
        @(posedge CLK);
        #1;
        n++;
        start = 1'b0;
        chk("ignore held result", 64'(result), 64'(last_exp.res));
        chk("ignore still busy", 64'(busy), 64'(1));
        wait_done("ignore", n, LAT_DIV);

        // Reset in the middle of a DIV aborts it with no done.
        @(negedge CLK);
        launch(2'd0, 16'd100, 16'd7);
        void'(exp_q.pop_back());
        repeat (4) @(posedge CLK);
        #1;
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort done", 64'(done), 64'(0));
        chk("abort result", 64'(result), 64'(0));
        idle_check("abort no done", 40);

        // start in the DONE cycle is accepted back-to-back.
        @(negedge CLK);
        launch(2'd0, 16'd2, 16'd3);
        wait_done("b2b first", 1, LAT_DIV);
        launch(2'd2, 16'd16, 16'd0);
        wait_done("b2b second", 1, LAT_SQRT);
        launch(2'd3, 16'd0, 16'd0);
        wait_done("b2b err", 1, LAT_ERR);

        idle_check("no stray done", 5);
        chk("scoreboard drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
